kv_cache_tag_ctrl: RTL and testbench
====================================

# kv_cache_tag_ctrl

Tag-lookup and miss-refill controller for the 4-way set-associative cache. It sits directly upstream of the LRU replacement block. For each request it drives that block's hit-way, valid-way and index inputs, and on a miss it consumes the registered kill mask to choose the victim way. It then runs a line refill handshake with the memory side and installs the new tag.

## Interface
- WAY_NUM, 4, number of ways (power of two).
- LINE_NUM, 64, total lines; sets = LINE_NUM/WAY_NUM; INDEX_WIDTH = clog2(sets).
- ADDR_WIDTH, 32, byte address width.
- LINE_BYTES, 16, line size; OFFSET_WIDTH = clog2(LINE_BYTES); TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_req_valid / o_req_ready  in/out  1  request handshake; accepted when both are high at a rising edge.
- i_req_addr  in  ADDR_WIDTH  request byte address.
- i_flush  in  1  level request to invalidate all lines.
- o_resp_valid  out  1  one-cycle response pulse.
- o_resp_hit  out  1  1 = hit, 0 = filled by refill.
- o_resp_way  out  WAY_NUM  one-hot way holding the line.
- o_valid_way  out  WAY_NUM  valid bits of the set at o_index (to LRU).
- o_hitway  out  WAY_NUM  one-hot way to mark most-recent (to LRU); 0 = no update.
- o_index  out  INDEX_WIDTH  set index (to LRU).
- i_killmask  in  WAY_NUM  LRU victim mask, registered one cycle after o_index/o_hitway.
- o_refill_valid / i_refill_ready  out/in  1  refill request handshake.
- o_refill_addr  out  ADDR_WIDTH  line-aligned miss address, low OFFSET_WIDTH bits = 0.
- i_refill_done  in  1  one-cycle pulse: line data has been written.

## Operation
- Storage: tag flops `tag[set][way]` (not reset) and valid flops `vld[set][way]` (reset to 0).
- FSM states: IDLE, LOOKUP, VICTIM, REFILL_REQ, REFILL_WAIT, FLUSH.
- IDLE: o_req_ready = 1 unless a flush is pending.
  - On accept, capture the address into r_addr and go to LOOKUP.
  - i_flush high (or flush pending) takes priority over a request: go to FLUSH.
- LOOKUP: hit vector = vld & (tag == r_addr tag) per way, for the set r_index.
  - Hit: o_hitway = hit vector; register the response; go to IDLE.
  - Miss: o_hitway = 0; go to VICTIM.
- VICTIM: sample i_killmask.
  - If any way is invalid, the victim is the lowest-numbered invalid way.
  - Otherwise the victim is the lowest set bit of i_killmask.
  - If i_killmask is 0, the victim is way WAY_NUM-1.
  - Go to REFILL_REQ.
- REFILL_REQ: hold o_refill_valid = 1 and a stable o_refill_addr until i_refill_ready; then go to REFILL_WAIT.
- REFILL_WAIT: on i_refill_done, write the tag, set vld, drive o_hitway = victim, register the response with hit = 0, and go to IDLE.
- FLUSH:
  - Clear vld of one set per cycle, counting set 0 up to sets-1.
  - o_req_ready = 0 throughout.
  - Return to IDLE after the last set; total time is `sets` cycles.
- i_flush seen outside IDLE/FLUSH is latched as pending and serviced at the next IDLE, before any request.
- A hit and an install never occur in the same cycle.
- o_hitway is nonzero only in a LOOKUP-hit cycle or a REFILL_WAIT-done cycle; in all other cycles it is 0.
- o_index = r_index in every non-IDLE state; in IDLE it holds its last value.
- o_valid_way = vld[o_index].
- Reset mid-refill: the FSM goes to IDLE, o_refill_valid drops immediately, and all valid bits clear.

## Timing
- Reset values:
  - o_req_ready = 1.
  - o_resp_valid, o_resp_hit, o_refill_valid = 0.
  - o_resp_way, o_hitway, o_index, o_refill_addr = 0.
  - o_valid_way = 0.
  - FSM state = IDLE.
- Hit latency: request accepted at edge N; LOOKUP during cycle N+1; o_resp_valid high for cycle N+2, when o_req_ready is already high again.
- Miss: o_refill_valid rises in cycle N+3 (after LOOKUP and VICTIM). The response is high the cycle after i_refill_done is sampled.
- i_killmask is sampled exactly one cycle after the LOOKUP cycle.
- Throughput: at most one request per 2 cycles on hits.

## Configuration
- KV_TAG_PARITY_EN defined:
  - Each tag entry stores an even-parity bit, written at install.
  - In LOOKUP, a tag match with a parity error is treated as a miss for that way.
  - The entry's vld is cleared in the same cycle, and output o_parity_err pulses for one cycle.
- KV_TAG_PARITY_EN undefined: no parity storage and no o_parity_err port.

## Test plan
- After reset, read 0x0000_0100 → miss; refill address 0x0000_0100; way 0001 installed; resp hit = 0, way = 0001.
- Read 0x0000_0104 again → resp in cycle N+2 with hit = 1, way = 0001; o_hitway = 0001 for one cycle; no refill.
- Fill 4 ways of set 0 (addresses 0x000, 0x100, 0x200, 0x300), then read 0x400 with i_killmask = 0100 → victim way 2; tag 0x400 replaces 0x200.
- Hold i_refill_ready = 0 for 5 cycles → o_refill_valid and o_refill_addr remain stable; no response until i_refill_done.
- Assert i_flush during REFILL_WAIT → refill completes, then 16 FLUSH cycles with ready = 0; the following read of 0x100 misses.
- Deassert i_rstn during REFILL_REQ → o_refill_valid = 0 asynchronously; all vld = 0; the next request misses.

Source files
------------

// File: rtl/kv_cache_tag_ctrl_if.sv
// kv_cache_tag_ctrl_if: request, response, LRU and refill signals of the
// 4-way tag controller. master = requester/memory side, slave = controller.
// Optional KV_TAG_PARITY_EN adds the o_parity_err pulse.
interface kv_cache_tag_ctrl_if #(
    parameter int WAY_NUM    = 4,
    parameter int LINE_NUM   = 64,
    parameter int ADDR_WIDTH = 32
);
    localparam int INDEX_WIDTH = $clog2(LINE_NUM / WAY_NUM);

    logic                   i_req_valid;
    logic                   o_req_ready;
    logic [ADDR_WIDTH-1:0]  i_req_addr;
    logic                   i_flush;
    logic                   o_resp_valid;
    logic                   o_resp_hit;
    logic [WAY_NUM-1:0]     o_resp_way;
    logic [WAY_NUM-1:0]     o_valid_way;
    logic [WAY_NUM-1:0]     o_hitway;
    logic [INDEX_WIDTH-1:0] o_index;
    logic [WAY_NUM-1:0]     i_killmask;
    logic                   o_refill_valid;
    logic                   i_refill_ready;
    logic [ADDR_WIDTH-1:0]  o_refill_addr;
    logic                   i_refill_done;
`ifdef KV_TAG_PARITY_EN
    logic                   o_parity_err;
`endif

    modport master (
        output i_req_valid, i_req_addr, i_flush, i_killmask, i_refill_ready, i_refill_done,
        input  o_req_ready, o_resp_valid, o_resp_hit, o_resp_way, o_valid_way, o_hitway,
               o_index, o_refill_valid, o_refill_addr
`ifdef KV_TAG_PARITY_EN
        , input o_parity_err
`endif
    );

    modport slave (
        input  i_req_valid, i_req_addr, i_flush, i_killmask, i_refill_ready, i_refill_done,
        output o_req_ready, o_resp_valid, o_resp_hit, o_resp_way, o_valid_way, o_hitway,
               o_index, o_refill_valid, o_refill_addr
`ifdef KV_TAG_PARITY_EN
        , output o_parity_err
`endif
    );
endinterface

// File: rtl/kv_cache_tag_ctrl.sv
// kv_cache_tag_ctrl: tag lookup and miss-refill controller for a 4-way
// set-associative cache, feeding the LRU block (index/hitway/valid_way) and
// taking its registered kill mask to pick a victim on a miss.
// Optional feature macro: KV_TAG_PARITY_EN (even parity per tag entry).
module kv_cache_tag_ctrl #(
    parameter int WAY_NUM    = 4,
    parameter int LINE_NUM   = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16
) (
    input logic                i_clk,
    input logic                i_rstn,
    kv_cache_tag_ctrl_if.slave bus
);
    localparam int SETS         = LINE_NUM / WAY_NUM;
    localparam int INDEX_WIDTH  = $clog2(SETS);
    localparam int OFFSET_WIDTH = $clog2(LINE_BYTES);
    localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    typedef enum logic [2:0] {IDLE, LOOKUP, VICTIM, REFILL_REQ, REFILL_WAIT, FLUSH} state_t;

    state_t                 state;
    logic [TAG_WIDTH-1:0]   tag_mem [SETS][WAY_NUM];
    logic [WAY_NUM-1:0]     vld [SETS];
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [WAY_NUM-1:0]     r_victim;
    logic                   flush_pend;
    logic [INDEX_WIDTH-1:0] flush_cnt;
    logic [WAY_NUM-1:0]     set_vld;
    logic [WAY_NUM-1:0]     match;
    logic [WAY_NUM-1:0]     hit_vec;
    logic [WAY_NUM-1:0]     victim_nxt;
    logic                   install;
    logic                   accept;
    logic                   flush_go;
    logic                   unused_offset;
`ifdef KV_TAG_PARITY_EN
    logic                   tag_par [SETS][WAY_NUM];
    logic [WAY_NUM-1:0]     perr;
`endif

    // One-hot of the lowest set bit of v (zero when v is zero).
    function automatic logic [WAY_NUM-1:0] lowest_one(input logic [WAY_NUM-1:0] v);
        lowest_one = '0;
        for (int i = WAY_NUM - 1; i >= 0; i--)
            if (v[i]) lowest_one = WAY_NUM'(1) << i;
    endfunction

    assign unused_offset = ^bus.i_req_addr[OFFSET_WIDTH-1:0];
    assign set_vld       = vld[r_index];
    assign install       = (state == REFILL_WAIT) && bus.i_refill_done;
    assign flush_go      = (state == IDLE) && (bus.i_flush || flush_pend);
    assign bus.o_req_ready = (state == IDLE) && !flush_pend && !bus.i_flush;
    assign accept        = bus.o_req_ready && bus.i_req_valid;
    assign bus.o_index     = r_index;
    assign bus.o_valid_way = set_vld;

    // Per-way tag compare for the captured set; parity errors demote a match to a miss.
    always_comb begin
        match = '0;
        for (int w = 0; w < WAY_NUM; w++)
            match[w] = set_vld[w] && (tag_mem[r_index][w] == r_tag);
`ifdef KV_TAG_PARITY_EN
        perr = '0;
        for (int w = 0; w < WAY_NUM; w++)
            perr[w] = match[w] && (tag_par[r_index][w] != ^r_tag);
        hit_vec = match & ~perr;
`else
        hit_vec = match;
`endif
    end

`ifdef KV_TAG_PARITY_EN
    assign bus.o_parity_err = (state == LOOKUP) && (|perr);
`endif

    // Victim: lowest invalid way, else lowest kill-mask bit, else the top way.
    always_comb begin
        victim_nxt = {1'b1, {(WAY_NUM-1){1'b0}}};
        if (|(~set_vld))
            victim_nxt = lowest_one(~set_vld);
        else if (|bus.i_killmask)
            victim_nxt = lowest_one(bus.i_killmask);
    end

    // LRU update strobe: hit way during a LOOKUP hit, installed way on refill completion.
    always_comb begin
        bus.o_hitway = '0;
        if (state == LOOKUP)
            bus.o_hitway = hit_vec;
        else if (install)
            bus.o_hitway = r_victim;
    end

    // Tag storage is written only on install and never reset.
    always_ff @(posedge i_clk) begin
        if (install) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                if (r_victim[w]) begin
                    tag_mem[r_index][w] <= r_tag;
`ifdef KV_TAG_PARITY_EN
                    tag_par[r_index][w] <= ^r_tag;
`endif
                end
            end
        end
    end

    // Controller FSM with valid bits, flush sequencing and registered response/refill outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state              <= IDLE;
            r_tag              <= '0;
            r_index            <= '0;
            r_victim           <= '0;
            flush_pend         <= 1'b0;
            flush_cnt          <= '0;
            bus.o_resp_valid   <= 1'b0;
            bus.o_resp_hit     <= 1'b0;
            bus.o_resp_way     <= '0;
            bus.o_refill_valid <= 1'b0;
            bus.o_refill_addr  <= '0;
            for (int s = 0; s < SETS; s++) vld[s] <= '0;
        end else begin
            bus.o_resp_valid <= 1'b0;
            if (bus.i_flush && (state != IDLE) && (state != FLUSH))
                flush_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush_go) begin
                        flush_pend <= 1'b0;
                        flush_cnt  <= '0;
                        state      <= FLUSH;
                    end else if (accept) begin
                        r_tag   <= bus.i_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                        r_index <= bus.i_req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
`ifdef KV_TAG_PARITY_EN
                    vld[r_index] <= set_vld & ~perr;
`endif
                    if (|hit_vec) begin
                        bus.o_resp_valid <= 1'b1;
                        bus.o_resp_hit   <= 1'b1;
                        bus.o_resp_way   <= hit_vec;
                        state            <= IDLE;
                    end else begin
                        state <= VICTIM;
                    end
                end
                VICTIM: begin
                    r_victim           <= victim_nxt;
                    bus.o_refill_valid <= 1'b1;
                    bus.o_refill_addr  <= {r_tag, r_index, {OFFSET_WIDTH{1'b0}}};
                    state              <= REFILL_REQ;
                end
                REFILL_REQ: begin
                    if (bus.i_refill_ready) begin
                        bus.o_refill_valid <= 1'b0;
                        state              <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (bus.i_refill_done) begin
                        vld[r_index]     <= set_vld | r_victim;
                        bus.o_resp_valid <= 1'b1;
                        bus.o_resp_hit   <= 1'b0;
                        bus.o_resp_way   <= r_victim;
                        state            <= IDLE;
                    end
                end
                FLUSH: begin
                    vld[flush_cnt] <= '0;
                    flush_cnt      <= flush_cnt + 1'b1;
                    if (flush_cnt == INDEX_WIDTH'(SETS - 1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kv_cache_tag_ctrl.sv
// tb_kv_cache_tag_ctrl: directed bench for the 4-way tag/refill controller.
module tb_kv_cache_tag_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    kv_cache_tag_ctrl_if bus ();

    kv_cache_tag_ctrl dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and service any refill; returns what was observed.
    task automatic run_req(input logic [31:0] addr, input logic [3:0] kill,
                           output logic rv, output logic h, output logic [3:0] w,
                           output logic rf, output logic [31:0] ra, output int lat,
                           output int rf_cyc, output logic [3:0] hw_l, output logic [3:0] hw_d);
        logic issued;
        int   c;
        rv = 0; h = 0; w = '0; rf = 0; ra = '0; lat = 0; rf_cyc = 0;
        hw_l = '0; hw_d = '0; issued = 0; c = 1;
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = addr;
        bus.i_killmask  = kill;
        tick();
        bus.i_req_valid = 1'b0;
        hw_l = bus.o_hitway;
        while (c < 40 && !rv) begin
            bus.i_refill_done = 1'b0;
            if (bus.o_resp_valid) begin
                rv = 1; h = bus.o_resp_hit; w = bus.o_resp_way; lat = c;
            end else begin
                if (issued) begin
                    bus.i_refill_ready = 1'b0;
                    bus.i_refill_done  = 1'b1;
                    issued = 0;
                    #1;
                    hw_d = bus.o_hitway;
                end else if (bus.o_refill_valid) begin
                    if (!rf) begin rf = 1; ra = bus.o_refill_addr; rf_cyc = c; end
                    bus.i_refill_ready = 1'b1;
                    issued = 1;
                end
                tick();
                c++;
            end
        end
        bus.i_refill_done  = 1'b0;
        bus.i_refill_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_req_valid = 0; bus.i_req_addr = '0; bus.i_flush = 0; bus.i_killmask = '0;
        bus.i_refill_ready = 0; bus.i_refill_done = 0;
        rstn = 1'b0;
        tick(); tick();
        nvec++; if (bus.o_req_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", bus.o_req_ready); end
        nvec++; if (bus.o_resp_valid !== 1'b0) begin nerr++; $display("FAIL rst_resp_valid: got %b want 0", bus.o_resp_valid); end
        nvec++; if (bus.o_resp_hit !== 1'b0) begin nerr++; $display("FAIL rst_resp_hit: got %b want 0", bus.o_resp_hit); end
        nvec++; if (bus.o_refill_valid !== 1'b0) begin nerr++; $display("FAIL rst_refill_valid: got %b want 0", bus.o_refill_valid); end
        nvec++; if (bus.o_resp_way !== 4'b0) begin nerr++; $display("FAIL rst_resp_way: got %b want 0000", bus.o_resp_way); end
        nvec++; if (bus.o_hitway !== 4'b0) begin nerr++; $display("FAIL rst_hitway: got %b want 0000", bus.o_hitway); end
        nvec++; if (bus.o_index !== 4'h0) begin nerr++; $display("FAIL rst_index: got %h want 0", bus.o_index); end
        nvec++; if (bus.o_refill_addr !== 32'h0) begin nerr++; $display("FAIL rst_refill_addr: got %h want 0", bus.o_refill_addr); end
        nvec++; if (bus.o_valid_way !== 4'b0) begin nerr++; $display("FAIL rst_valid_way: got %b want 0000", bus.o_valid_way); end
        @(negedge clk) rstn = 1'b1;
        tick();
        nvec++; if (bus.o_req_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_ready: got %b want 1", bus.o_req_ready); end
    endtask

    task automatic test_miss_refill();
        logic rv, h, rf; logic [3:0] w, hl, hd; logic [31:0] ra; int lat, rc;
        run_req(32'h0000_0100, 4'b0000, rv, h, w, rf, ra, lat, rc, hl, hd);
        nvec++; if (rv !== 1'b1) begin nerr++; $display("FAIL miss_resp: got %b want 1", rv); end
        nvec++; if (h !== 1'b0) begin nerr++; $display("FAIL miss_hit: got %b want 0", h); end
        nvec++; if (w !== 4'b0001) begin nerr++; $display("FAIL miss_way: got %b want 0001", w); end
        nvec++; if (rf !== 1'b1 || ra !== 32'h0000_0100) begin nerr++; $display("FAIL miss_refill_addr: got %b/%h want 1/00000100", rf, ra); end
        nvec++; if (rc != 3) begin nerr++; $display("FAIL miss_refill_cycle: got %0d want 3", rc); end
        nvec++; if (lat != 5) begin nerr++; $display("FAIL miss_latency: got %0d want 5", lat); end
        nvec++; if (hl !== 4'b0000) begin nerr++; $display("FAIL miss_lookup_hitway: got %b want 0000", hl); end
        nvec++; if (hd !== 4'b0001) begin nerr++; $display("FAIL miss_install_hitway: got %b want 0001", hd); end
        nvec++; if (bus.o_valid_way !== 4'b0001) begin nerr++; $display("FAIL miss_valid_way: got %b want 0001", bus.o_valid_way); end
    endtask

    task automatic test_hit();
        logic rv, h, rf; logic [3:0] w, hl, hd; logic [31:0] ra; int lat, rc;
        run_req(32'h0000_0104, 4'b0000, rv, h, w, rf, ra, lat, rc, hl, hd);
        nvec++; if (rv !== 1'b1 || h !== 1'b1) begin nerr++; $display("FAIL hit_resp: got %b/%b want 1/1", rv, h); end
        nvec++; if (w !== 4'b0001) begin nerr++; $display("FAIL hit_way: got %b want 0001", w); end
        nvec++; if (lat != 2) begin nerr++; $display("FAIL hit_latency: got %0d want 2", lat); end
        nvec++; if (rf !== 1'b0) begin nerr++; $display("FAIL hit_no_refill: got %b want 0", rf); end
        nvec++; if (hl !== 4'b0001) begin nerr++; $display("FAIL hit_hitway: got %b want 0001", hl); end
        nvec++; if (bus.o_req_ready !== 1'b1) begin nerr++; $display("FAIL hit_ready_at_resp: got %b want 1", bus.o_req_ready); end
        nvec++; if (bus.o_hitway !== 4'b0000) begin nerr++; $display("FAIL hit_hitway_after: got %b want 0000", bus.o_hitway); end
    endtask

    task automatic test_back_to_back();
        logic rv, h, rf; logic [3:0] w, hl, hd; logic [31:0] ra; int lat, rc;
        run_req(32'h0000_0108, 4'b0000, rv, h, w, rf, ra, lat, rc, hl, hd);
        nvec++; if (rv !== 1'b1 || h !== 1'b1 || lat != 2) begin nerr++; $display("FAIL b2b_hit1: got %b/%b/%0d want 1/1/2", rv, h, lat); end
        run_req(32'h0000_010C, 4'b0000, rv, h, w, rf, ra, lat, rc, hl, hd);
        nvec++; if (rv !== 1'b1 || h !== 1'b1 || lat != 2 || w !== 4'b0001) begin nerr++; $display("FAIL b2b_hit2: got %b/%b/%0d/%b want 1/1/2/0001", rv, h, lat, w); end
    endtask

    task automatic test_victim();
        logic rv, h, rf; logic [3:0] w, hl, hd; logic [31:0] ra; int lat, rc;
        logic [31:0] addrs [4] = '{32'h000, 32'h200, 32'h300, 32'h400};
        logic [3:0]  kills [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100};
        logic [3:0]  ways  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100};
        for (int i = 0; i < 4; i++) begin
            run_req(addrs[i], kills[i], rv, h, w, rf, ra, lat, rc, hl, hd);
            nvec++; if (rv !== 1'b1 || h !== 1'b0 || w !== ways[i] || ra !== addrs[i]) begin
                nerr++; $display("FAIL victim_fill%0d: got %b/%b/%b/%h want 1/0/%b/%h", i, rv, h, w, ra, ways[i], addrs[i]);
            end
        end
        nvec++; if (bus.o_valid_way !== 4'b1111) begin nerr++; $display("FAIL victim_all_valid: got %b want 1111", bus.o_valid_way); end
        run_req(32'h200, 4'b0000, rv, h, w, rf, ra, lat, rc, hl, hd);
        nvec++; if (h !== 1'b0 || w !== 4'b1000) begin nerr++; $display("FAIL victim_replaced_zero_kill: got %b/%b want 0/1000", h, w); end
        run_req(32'h500, 4'b1010, rv, h, w, rf, ra, lat, rc, hl, hd);
        nvec++; if (h !== 1'b0 || w !== 4'b0010) begin nerr++; $display("FAIL victim_multi_kill: got %b/%b want 0/0010", h, w); end
        run_req(32'h404, 4'b0000, rv, h, w, rf, ra, lat, rc, hl, hd);
        nvec++; if (h !== 1'b1 || w !== 4'b0100) begin nerr++; $display("FAIL victim_new_hit: got %b/%b want 1/0100", h, w); end
        run_req(32'h100, 4'b0000, rv, h, w, rf, ra, lat, rc, hl, hd);
        nvec++; if (h !== 1'b1 || w !== 4'b0001) begin nerr++; $display("FAIL victim_keep_way0: got %b/%b want 1/0001", h, w); end
    endtask

    task automatic test_refill_stall();
        bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_0A34; bus.i_killmask = 4'b0000;
        tick();
        bus.i_req_valid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            nvec++; if (bus.o_refill_valid !== 1'b1 || bus.o_refill_addr !== 32'h0000_0A30) begin
                nerr++; $display("FAIL stall_hold%0d: got %b/%h want 1/00000a30", i, bus.o_refill_valid, bus.o_refill_addr);
            end
            nvec++; if (bus.o_resp_valid !== 1'b0) begin nerr++; $display("FAIL stall_noresp%0d: got %b want 0", i, bus.o_resp_valid); end
            tick();
        end
        bus.i_refill_ready = 1'b1;
        tick();
        bus.i_refill_ready = 1'b0;
        nvec++; if (bus.o_refill_valid !== 1'b0) begin nerr++; $display("FAIL stall_refill_drop: got %b want 0", bus.o_refill_valid); end
        tick(); tick();
        nvec++; if (bus.o_resp_valid !== 1'b0) begin nerr++; $display("FAIL stall_wait_noresp: got %b want 0", bus.o_resp_valid); end
        bus.i_refill_done = 1'b1;
        #1;
        nvec++; if (bus.o_hitway !== 4'b0001) begin nerr++; $display("FAIL stall_install_hitway: got %b want 0001", bus.o_hitway); end
        tick();
        bus.i_refill_done = 1'b0;
        nvec++; if (bus.o_resp_valid !== 1'b1 || bus.o_resp_hit !== 1'b0 || bus.o_resp_way !== 4'b0001) begin
            nerr++; $display("FAIL stall_resp: got %b/%b/%b want 1/0/0001", bus.o_resp_valid, bus.o_resp_hit, bus.o_resp_way);
        end
    endtask

    task automatic test_flush();
        logic rv, h, rf; logic [3:0] w, hl, hd; logic [31:0] ra; int lat, rc, n;
        bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_0B40; bus.i_killmask = 4'b0000;
        tick();
        bus.i_req_valid = 1'b0;
        tick(); tick();
        bus.i_refill_ready = 1'b1;
        tick();
        bus.i_refill_ready = 1'b0;
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        bus.i_refill_done = 1'b1;
        tick();
        bus.i_refill_done = 1'b0;
        nvec++; if (bus.o_resp_valid !== 1'b1 || bus.o_resp_way !== 4'b0001) begin nerr++; $display("FAIL flush_refill_done: got %b/%b want 1/0001", bus.o_resp_valid, bus.o_resp_way); end
        nvec++; if (bus.o_req_ready !== 1'b0) begin nerr++; $display("FAIL flush_pending_ready: got %b want 0", bus.o_req_ready); end
        bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_0100;
        n = 0;
        do begin tick(); n++; end while (bus.o_req_ready === 1'b0 && n < 40);
        bus.i_req_valid = 1'b0;
        nvec++; if (n != 17) begin nerr++; $display("FAIL flush_cycles: got %0d want 17", n); end
        nvec++; if (bus.o_valid_way !== 4'b0000) begin nerr++; $display("FAIL flush_cleared: got %b want 0000", bus.o_valid_way); end
        run_req(32'h0000_0100, 4'b0000, rv, h, w, rf, ra, lat, rc, hl, hd);
        nvec++; if (rv !== 1'b1 || h !== 1'b0 || rf !== 1'b1 || w !== 4'b0001) begin
            nerr++; $display("FAIL flush_then_miss: got %b/%b/%b/%b want 1/0/1/0001", rv, h, rf, w);
        end
    endtask

    task automatic test_reset_midrefill();
        logic rv, h, rf; logic [3:0] w, hl, hd; logic [31:0] ra; int lat, rc;
        bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_0C50; bus.i_killmask = 4'b0000;
        tick();
        bus.i_req_valid = 1'b0;
        tick(); tick();
        nvec++; if (bus.o_refill_valid !== 1'b1) begin nerr++; $display("FAIL midrst_refill_up: got %b want 1", bus.o_refill_valid); end
        #1 rstn = 1'b0;
        #1;
        nvec++; if (bus.o_refill_valid !== 1'b0) begin nerr++; $display("FAIL midrst_refill_async: got %b want 0", bus.o_refill_valid); end
        nvec++; if (bus.o_valid_way !== 4'b0000 || bus.o_req_ready !== 1'b1) begin
            nerr++; $display("FAIL midrst_state: got %b/%b want 0000/1", bus.o_valid_way, bus.o_req_ready);
        end
        @(negedge clk) rstn = 1'b1;
        tick();
        run_req(32'h0000_0100, 4'b0000, rv, h, w, rf, ra, lat, rc, hl, hd);
        nvec++; if (rv !== 1'b1 || h !== 1'b0 || rf !== 1'b1 || ra !== 32'h0000_0100) begin
            nerr++; $display("FAIL midrst_next_miss: got %b/%b/%b/%h want 1/0/1/00000100", rv, h, rf, ra);
        end
    endtask

    initial begin
        test_reset();
        test_miss_refill();
        test_hit();
        test_back_to_back();
        test_victim();
        test_refill_stall();
        test_flush();
        test_reset_midrefill();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
